// File: rtl/bids_pkg.sv
// Shared constants for the bid-controller host sequencer.
// Holds the bid controller opcodes, its err codes and the sequencer state
// encoding (which is also reported on fail_step).
package bids_pkg;

    localparam int unsigned CTRL_OP_W = 4;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ERR_W     = 3;
    localparam int unsigned STATE_W   = 4;

    // Bid controller opcodes
    localparam logic [CTRL_OP_W-1:0] OP_NOP       = 4'd0;
    localparam logic [CTRL_OP_W-1:0] OP_UNLOCK    = 4'd1;
    localparam logic [CTRL_OP_W-1:0] OP_LOCK      = 4'd2;
    localparam logic [CTRL_OP_W-1:0] OP_LOADX     = 4'd3;
    localparam logic [CTRL_OP_W-1:0] OP_LOADY     = 4'd4;
    localparam logic [CTRL_OP_W-1:0] OP_LOADZ     = 4'd5;
    localparam logic [CTRL_OP_W-1:0] OP_SETMASK   = 4'd6;
    localparam logic [CTRL_OP_W-1:0] OP_SETTIMER  = 4'd7;
    localparam logic [CTRL_OP_W-1:0] OP_BIDCHARGE = 4'd8;

    // Bid controller err codes; ERR_TIMEOUT is generated locally
    localparam logic [ERR_W-1:0] ERR_NONE           = 3'd0;
    localparam logic [ERR_W-1:0] ERR_BADKEY         = 3'd1;
    localparam logic [ERR_W-1:0] ERR_UNLOCKED       = 3'd2;
    localparam logic [ERR_W-1:0] ERR_START_UNLOCKED = 3'd3;
    localparam logic [ERR_W-1:0] ERR_INVALID        = 3'd4;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT        = 3'd7;

    // Sequencer states; LDX..LOCK..RUN are consecutive so op states step by +1
    typedef logic [STATE_W-1:0] seq_state_t;
    localparam seq_state_t ST_IDLE     = 4'd0;
    localparam seq_state_t ST_WAIT_RDY = 4'd1;
    localparam seq_state_t ST_LDX      = 4'd2;
    localparam seq_state_t ST_LDY      = 4'd3;
    localparam seq_state_t ST_LDZ      = 4'd4;
    localparam seq_state_t ST_MASK     = 4'd5;
    localparam seq_state_t ST_TIMER    = 4'd6;
    localparam seq_state_t ST_COST     = 4'd7;
    localparam seq_state_t ST_LOCK     = 4'd8;
    localparam seq_state_t ST_RUN      = 4'd9;
    localparam seq_state_t ST_DRAIN    = 4'd10;
    localparam seq_state_t ST_CAPTURE  = 4'd11;
    localparam seq_state_t ST_UNLOCK   = 4'd12;
    localparam seq_state_t ST_FAIL     = 4'd13;

    // Opcode presented while the sequencer sits in a given state
    function automatic logic [CTRL_OP_W-1:0] state_op(input seq_state_t st);
        logic [CTRL_OP_W-1:0] op;
        op = OP_NOP;
        case (st)
            ST_LDX:    op = OP_LOADX;
            ST_LDY:    op = OP_LOADY;
            ST_LDZ:    op = OP_LOADZ;
            ST_MASK:   op = OP_SETMASK;
            ST_TIMER:  op = OP_SETTIMER;
            ST_COST:   op = OP_BIDCHARGE;
            ST_LOCK:   op = OP_LOCK;
            ST_UNLOCK: op = OP_UNLOCK;
            default:   op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/bids_seq_timer.sv
// Loadable down-counter with a zero flag, shared between the RUN length
// count and the ready/roundOver wait timeouts.
// Ports: clk, reset (sync, active-high), load/load_val (load wins over dec),
//        dec (count down, saturating at zero), zero_c (count is zero).
module bids_seq_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero_c
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load, else saturating decrement
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_c = (count_q == '0);

endmodule

// File: rtl/bids_round_sequencer.sv
// Host-side sequencer that runs one complete auction round on the bid
// controller: wait ready, load balances, mask, timer, charge, lock, hold
// C_start for cfg_len cycles, wait roundOver, capture results, unlock.
// Ports: go + cfg_* (round request/config), ready/err/roundOver/maxBid/win
//        (from bid controller), C_op/C_data/C_start (to bid controller),
//        busy/done/fail/fail_code/fail_step/res_max/res_win (status/results).
//        All outputs are registered.
module bids_round_sequencer
    import bids_pkg::*;
#(
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned OP_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [31:0]      cfg_x,
    input  logic [31:0]      cfg_y,
    input  logic [31:0]      cfg_z,
    input  logic [2:0]       cfg_mask,
    input  logic [3:0]       cfg_timer,
    input  logic [31:0]      cfg_cost,
    input  logic [31:0]      cfg_key,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             ready,
    input  logic [2:0]       err,
    input  logic             roundOver,
    input  logic [31:0]      maxBid,
    input  logic [2:0]       win,
    output logic [OP_W-1:0]  C_op,
    output logic [31:0]      C_data,
    output logic             C_start,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [2:0]       fail_code,
    output logic [3:0]       fail_step,
    output logic [31:0]      res_max,
    output logic [2:0]       res_win
);

    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned TMR_W = (LEN_W > TO_W) ? LEN_W : TO_W;

    seq_state_t         state_q, state_d;
    logic [31:0]        cfg_x_q, cfg_x_d;
    logic [31:0]        cfg_y_q, cfg_y_d;
    logic [31:0]        cfg_z_q, cfg_z_d;
    logic [2:0]         cfg_mask_q, cfg_mask_d;
    logic [3:0]         cfg_timer_q, cfg_timer_d;
    logic [31:0]        cfg_cost_q, cfg_cost_d;
    logic [31:0]        cfg_key_q, cfg_key_d;
    logic [LEN_W-1:0]   cfg_len_q, cfg_len_d;
    logic [OP_W-1:0]    c_op_q, c_op_d;
    logic [DATA_W-1:0]  c_data_q, c_data_d;
    logic               c_start_q, c_start_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fail_q, fail_d;
    logic [ERR_W-1:0]   fail_code_q, fail_code_d;
    logic [STATE_W-1:0] fail_step_q, fail_step_d;
    logic [31:0]        res_max_q, res_max_d;
    logic [2:0]         res_win_q, res_win_d;

    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic [TMR_W-1:0]   run_val;
    logic               tmr_zero_c;

    // Next-state, config latch, status and result capture
    always_comb begin
        state_d     = state_q;
        cfg_x_d     = cfg_x_q;
        cfg_y_d     = cfg_y_q;
        cfg_z_d     = cfg_z_q;
        cfg_mask_d  = cfg_mask_q;
        cfg_timer_d = cfg_timer_q;
        cfg_cost_d  = cfg_cost_q;
        cfg_key_d   = cfg_key_q;
        cfg_len_d   = cfg_len_q;
        fail_code_d = fail_code_q;
        fail_step_d = fail_step_q;
        res_max_d   = res_max_q;
        res_win_d   = res_win_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d     = ST_WAIT_RDY;
                    cfg_x_d     = cfg_x;
                    cfg_y_d     = cfg_y;
                    cfg_z_d     = cfg_z;
                    cfg_mask_d  = cfg_mask;
                    cfg_timer_d = cfg_timer;
                    cfg_cost_d  = cfg_cost;
                    cfg_key_d   = cfg_key;
                    cfg_len_d   = cfg_len;
                    fail_code_d = ERR_NONE;
                    fail_step_d = '0;
                end
            end
            ST_WAIT_RDY: begin
                if (ready) begin
                    state_d = ST_LDX;
                end else if (tmr_zero_c) begin
                    state_d     = ST_FAIL;
                    fail_code_d = ERR_TIMEOUT;
                    fail_step_d = state_q;
                end
            end
            ST_LDX, ST_LDY, ST_LDZ, ST_MASK, ST_TIMER, ST_COST, ST_LOCK: begin
                if (err != ERR_NONE) begin
                    state_d     = ST_FAIL;
                    fail_code_d = err;
                    fail_step_d = state_q;
                end else begin
                    state_d = state_q + STATE_W'(1);
                end
            end
            ST_RUN: begin
                // err is deliberately ignored while bidding is live
                if (tmr_zero_c) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (roundOver) begin
                    state_d = ST_CAPTURE;
                end else if (tmr_zero_c) begin
                    state_d     = ST_FAIL;
                    fail_code_d = ERR_TIMEOUT;
                    fail_step_d = state_q;
                end
            end
            ST_CAPTURE: begin
                res_max_d = maxBid;
                res_win_d = win;
                state_d   = ST_UNLOCK;
            end
            ST_UNLOCK: begin
                if (err != ERR_NONE) begin
                    state_d     = ST_FAIL;
                    fail_code_d = err;
                    fail_step_d = state_q;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_FAIL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller-facing outputs follow the state being entered so they are
    // registered yet valid for the whole cycle of that state
    always_comb begin
        c_op_d    = OP_W'(state_op(state_d));
        c_start_d = (state_d == ST_RUN);
        busy_d    = (state_d != ST_IDLE);
        fail_d    = (state_d == ST_FAIL);
        c_data_d  = '0;
        case (state_d)
            ST_LDX:             c_data_d = cfg_x_q;
            ST_LDY:             c_data_d = cfg_y_q;
            ST_LDZ:             c_data_d = cfg_z_q;
            ST_MASK:            c_data_d = DATA_W'(cfg_mask_q);
            ST_TIMER:           c_data_d = DATA_W'(cfg_timer_q);
            ST_COST:            c_data_d = cfg_cost_q;
            ST_LOCK, ST_UNLOCK: c_data_d = cfg_key_q;
            default:            c_data_d = '0;
        endcase
    end

    // Timer reloads on every state entry; RUN counts max(cfg_len,1) cycles
    always_comb begin
        run_val  = (cfg_len_q == '0) ? '0 : TMR_W'(cfg_len_q - LEN_W'(1));
        tmr_load = (state_d != state_q);
        tmr_val  = (state_d == ST_RUN) ? run_val : TMR_W'(TIMEOUT - 1);
    end

    bids_seq_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (1'b1),
        .zero_c   (tmr_zero_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cfg_x_q     <= '0;
            cfg_y_q     <= '0;
            cfg_z_q     <= '0;
            cfg_mask_q  <= '0;
            cfg_timer_q <= '0;
            cfg_cost_q  <= '0;
            cfg_key_q   <= '0;
            cfg_len_q   <= '0;
            c_op_q      <= '0;
            c_data_q    <= '0;
            c_start_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_code_q <= '0;
            fail_step_q <= '0;
            res_max_q   <= '0;
            res_win_q   <= '0;
        end else begin
            state_q     <= state_d;
            cfg_x_q     <= cfg_x_d;
            cfg_y_q     <= cfg_y_d;
            cfg_z_q     <= cfg_z_d;
            cfg_mask_q  <= cfg_mask_d;
            cfg_timer_q <= cfg_timer_d;
            cfg_cost_q  <= cfg_cost_d;
            cfg_key_q   <= cfg_key_d;
            cfg_len_q   <= cfg_len_d;
            c_op_q      <= c_op_d;
            c_data_q    <= c_data_d;
            c_start_q   <= c_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            fail_code_q <= fail_code_d;
            fail_step_q <= fail_step_d;
            res_max_q   <= res_max_d;
            res_win_q   <= res_win_d;
        end
    end

    assign C_op      = c_op_q;
    assign C_data    = c_data_q;
    assign C_start   = c_start_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign fail_code = fail_code_q;
    assign fail_step = fail_step_q;
    assign res_max   = res_max_q;
    assign res_win   = res_win_q;

endmodule

// File: doc/bids_round_sequencer.md
Name: bids_round_sequencer

Overview:
- Host-side controller that drives the bid controller's C_op/C_data/C_start interface.
- Takes one latched round configuration and runs a full auction round in a fixed order: load X/Y/Z balances, set mask, set timer, set bid charge, lock, hold C_start for a programmed number of cycles, wait for roundOver, capture results, unlock.
- Reports completion or the first error. Sits between the system CPU/testbench and the bid controller.

Parameters:
- LEN_W, 16, width of the round-length field.
- TIMEOUT, 64, max cycles to wait for ready or roundOver before failing.
- OP_W, 4, opcode width; must match the bid controller's C_op.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- go  in  1  one-cycle request to run a round with the cfg_* values; ignored while busy=1.
- cfg_x, cfg_y, cfg_z  in  32 each  initial balances.
- cfg_mask  in  3  bidder enable mask {X,Y,Z}.
- cfg_timer  in  4  bad-key lockout timer value.
- cfg_cost  in  32  per-bid charge.
- cfg_key  in  32  lock key.
- cfg_len  in  LEN_W  number of cycles C_start is held high.
- ready  in  1  from bid controller.
- err  in  3  from bid controller.
- roundOver  in  1  from bid controller.
- maxBid  in  32  from bid controller.
- win  in  3  {X_win,Y_win,Z_win} from bid controller.
- C_op  out  OP_W  opcode to bid controller.
- C_data  out  32  operand to bid controller.
- C_start  out  1  round-active request.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse on successful completion.
- fail  out  1  one-cycle pulse on abort.
- fail_code  out  3  err value or 3'b111 for timeout; held until next go.
- fail_step  out  4  state encoding where the failure occurred; held until next go.
- res_max  out  32  captured maxBid.
- res_win  out  3  captured winner vector.

Behaviour:
- Reset values: C_op=0 (NoOperation), C_data=0, C_start=0, busy=0, done=0, fail=0, fail_code=0, fail_step=0, res_max=0, res_win=0, all cfg registers=0, state=IDLE.
- Reset mid-sequence returns to IDLE in one cycle with C_start=0; no done or fail pulse.
- go accepted in IDLE only:
  - All cfg_* are latched on that edge; later cfg changes do not affect the running round.
  - busy rises the next cycle.
  - fail_code and fail_step clear.
- States: IDLE -> WAIT_RDY -> LDX -> LDY -> LDZ -> MASK -> TIMER -> COST -> LOCK -> RUN -> DRAIN -> CAPTURE -> UNLOCK -> IDLE. Any failure -> FAIL -> IDLE.
- WAIT_RDY:
  - C_op=0.
  - Advance on the first cycle ready=1.
  - Fail with code 3'b111 after TIMEOUT cycles.
- Op states LDX..LOCK and UNLOCK:
  - Each is exactly one cycle; C_op/C_data are registered outputs valid for that whole cycle.
  - Opcodes: LoadX=3, LoadY=4, LoadZ=5, SetMask=6 (data zero-extended), SetTimer=7, BidCharge=8, Lock=2, Unlock=1; data=cfg_key for both Lock and Unlock.
  - err is sampled at the end of the op cycle. Nonzero -> FAIL with fail_code=err and fail_step=current state. Zero -> advance.
- RUN:
  - C_start=1 and C_op=0 for max(cfg_len,1) cycles, counted by a LEN_W down-counter; cfg_len=0 behaves as 1.
  - err is ignored during RUN; per-bidder errors belong to the bidders.
- DRAIN:
  - C_start=0 and C_op=0.
  - Wait for roundOver=1; fail 3'b111 after TIMEOUT cycles.
  - Advance on the first cycle roundOver=1.
- CAPTURE: one cycle; res_max<=maxBid and res_win<=win are sampled while roundOver=1.
- UNLOCK: Unlock op. On err=0, done pulses the cycle after UNLOCK and busy falls at the same time.
- FAIL:
  - One cycle; fail=1 and C_start=0.
  - Then IDLE; the bid controller is left in whatever mode it reached.
- Timeout counter resets on every state entry.
- go together with reset: reset wins.
- go while busy: dropped; no queueing.

Decomposition:
- Package bids_pkg:
  - Opcode constants (NoOperation..BidCharge).
  - err code constants (none=0, badkey=1, unlocked=2, start_unlocked=3, invalid=4, timeout=7).
  - Sequencer state enum, also used as the fail_step encoding.
- One sub-module, bids_seq_timer: a loadable down-counter with a zero flag. It is shared for the RUN length and the TIMEOUT waits.

Test Plan:
- Normal round:
  - Stimulus: go with x=100, y=200, z=300, mask=3'b111, timer=4, cost=1, key=32'hA5A5, len=3; the bidder model bids X=10 and Y=20.
  - Required: op sequence 3,4,5,6,7,8,2; C_start high for exactly 3 cycles, then Unlock with 32'hA5A5.
  - Required: done pulse, res_max=20, res_win=3'b010, fail never asserted.
- len=0: go with len=0 -> C_start high for exactly 1 cycle; done pulse.
- Error injection: bid controller model returns err=3'b100 on the Lock cycle -> fail pulse, fail_code=3'b100, fail_step=LOCK, C_start never asserted.
- roundOver timeout: roundOver held 0 after RUN -> fail exactly TIMEOUT cycles after DRAIN entry, fail_code=3'b111, fail_step=DRAIN.
- Busy and config isolation:
  - Stimulus: second go during RUN with cfg_x=999.
  - Required: go ignored; no second sequence; the latched cfg is unchanged.
- Reset mid-RUN: reset asserted during RUN -> next cycle C_start=0, busy=0, all outputs at reset values, no done or fail pulse.
